// File: rtl/yolo_stream_pkg.sv
// rtl/yolo_stream_pkg.sv - shared types and default geometry for the YOLO frame streamer
package yolo_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int PIX_W_DEF      = 24;
    localparam int IMG_W_DEF      = 416;
    localparam int IMG_H_DEF      = 416;
    localparam int MAX_FRAMES_DEF = 2;

    localparam int FRAME_PIX = IMG_W_DEF * IMG_H_DEF;
    localparam int ADDR_W    = $clog2(FRAME_PIX * MAX_FRAMES_DEF);
    localparam int FRAME_W   = $clog2(MAX_FRAMES_DEF + 1);

    typedef struct packed {
        logic [PIX_W_DEF-1:0] tdata;
        logic                 tlast;
        logic                 tuser;
    } beat_t;

    function automatic int calc_addr_w(input int img_w, input int img_h, input int max_frames);
        return $clog2(img_w * img_h * max_frames);
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// rtl/stream_skid_fifo.sv - 2-entry fall-through FIFO holding packed {tdata, tlast, tuser} beats
module stream_skid_fifo
    import yolo_stream_pkg::*;
#(
    parameter int W = $bits(beat_t)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_wdata,
    input  logic         i_push,
    input  logic         i_ready,
    output logic [W-1:0] o_rdata,
    output logic         o_valid,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    logic w_empty;
    logic w_pop;
    logic w_store;
    logic w_pop_stored;

    // An empty FIFO presents the incoming word directly so the first beat is not delayed.
    assign w_empty      = (r_count == 2'd0);
    assign o_valid      = !w_empty || i_push;
    assign o_rdata      = w_empty ? i_wdata : r_mem[r_rd_ptr];
    assign o_count      = r_count;
    assign w_pop        = o_valid && i_ready;
    assign w_store      = i_push && !(w_empty && w_pop);
    assign w_pop_stored = w_pop && !w_empty;

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop_stored) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_store} - {1'b0, w_pop_stored};
        end
    end

endmodule

// File: rtl/yolo_frame_streamer.sv
// rtl/yolo_frame_streamer.sv - multi-frame pixel streamer with detection counting and timeout
module yolo_frame_streamer
    import yolo_stream_pkg::*;
#(
    parameter  int PIX_W          = 24,
    parameter  int IMG_W          = 416,
    parameter  int IMG_H          = 416,
    parameter  int MAX_FRAMES     = 2,
    parameter  int DETS_PER_FRAME = 338,
    parameter  int DET_W          = 16,
    parameter  int TIMEOUT        = 65536,
    localparam int F_PIX          = IMG_W * IMG_H,
    localparam int A_W            = calc_addr_w(IMG_W, IMG_H, MAX_FRAMES),
    localparam int F_W            = $clog2(MAX_FRAMES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [F_W-1:0]   num_frames,
    output logic             mem_rd_en,
    output logic [A_W-1:0]   mem_addr,
    input  logic [PIX_W-1:0] mem_rd_data,
    output logic [PIX_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    input  logic             det_valid,
    output logic             busy,
    output logic             done,
    output logic [DET_W-1:0] det_count,
    output logic             det_timeout
);

    localparam int CNT_W  = A_W + 1;
    localparam int P_W    = $clog2(F_PIX + 1);
    localparam int COL_W  = $clog2(IMG_W + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int BEAT_W = PIX_W + 2;

    state_t r_state;
    state_t w_state_next;

    logic [F_W-1:0]    r_nframes;
    logic [CNT_W-1:0]  r_total;
    logic [CNT_W-1:0]  r_rd_cnt;
    logic [P_W-1:0]    r_rd_p;
    logic [COL_W-1:0]  r_rd_col;
    logic [CNT_W-1:0]  r_acc_cnt;
    logic              r_inflight;
    logic              r_if_tlast;
    logic              r_if_tuser;
    logic              r_det_prev;
    logic [DET_W-1:0]  r_det_count;
    logic [IDLE_W-1:0] r_idle;
    logic              r_timeout;

    logic [F_W-1:0]    w_nf_clamped;
    logic              w_accept;
    logic              w_rd_en;
    logic              w_hs;
    logic              w_last_hs;
    logic              w_det_edge;
    logic [DET_W-1:0]  w_det_next;
    logic [31:0]       w_target;
    logic              w_target_hit;
    logic              w_idle_expired;
    logic              w_timeout_set;
    logic [BEAT_W-1:0] w_fifo_rdata;
    logic              w_fifo_valid;
    logic [1:0]        w_fifo_count;

    assign w_nf_clamped = (num_frames > F_W'(MAX_FRAMES)) ? F_W'(MAX_FRAMES) : num_frames;
    assign w_accept     = (r_state == ST_IDLE) && start;
    assign w_hs         = w_fifo_valid && m_axis_tready;
    assign w_last_hs    = w_hs && (r_acc_cnt == (r_total - CNT_W'(1)));

    assign w_det_edge = det_valid && !r_det_prev &&
                        ((r_state == ST_STREAM) || (r_state == ST_DRAIN));
    assign w_det_next = (w_det_edge && (r_det_count != '1)) ? r_det_count + DET_W'(1) : r_det_count;

    // Completion looks at the post-update count so an edge in the deciding cycle is included.
    assign w_target       = 32'(r_nframes) * 32'(DETS_PER_FRAME);
    assign w_target_hit   = (32'(w_det_next) == w_target);
    assign w_idle_expired = !w_det_edge && (r_idle == IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_timeout_set = 1'b0;
        w_rd_en       = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (w_nf_clamped == '0) ? ST_DONE : ST_STREAM;
                end
            end
            ST_STREAM: begin
                busy    = 1'b1;
                w_rd_en = (r_rd_cnt != r_total) &&
                          (({1'b0, w_fifo_count} + {2'b00, r_inflight}) < 3'd2);
                if (w_last_hs) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (w_target_hit) begin
                    w_state_next = ST_DONE;
                end else if (w_idle_expired) begin
                    w_state_next  = ST_DONE;
                    w_timeout_set = 1'b1;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_nframes   <= '0;
            r_total     <= '0;
            r_rd_cnt    <= '0;
            r_rd_p      <= '0;
            r_rd_col    <= '0;
            r_acc_cnt   <= '0;
            r_inflight  <= 1'b0;
            r_if_tlast  <= 1'b0;
            r_if_tuser  <= 1'b0;
            r_det_prev  <= 1'b0;
            r_det_count <= '0;
            r_idle      <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_det_prev <= det_valid;
            r_inflight <= w_rd_en;
            r_if_tlast <= (r_rd_col == COL_W'(IMG_W - 1));
            r_if_tuser <= (r_rd_p == '0);
            if (w_accept) begin
                r_nframes   <= w_nf_clamped;
                r_total     <= CNT_W'(w_nf_clamped) * CNT_W'(F_PIX);
                r_rd_cnt    <= '0;
                r_rd_p      <= '0;
                r_rd_col    <= '0;
                r_acc_cnt   <= '0;
                r_det_count <= '0;
                r_idle      <= '0;
                r_timeout   <= 1'b0;
            end else begin
                if (w_rd_en) begin
                    r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                    r_rd_p   <= (r_rd_p == P_W'(F_PIX - 1)) ? '0 : r_rd_p + P_W'(1);
                    r_rd_col <= (r_rd_col == COL_W'(IMG_W - 1)) ? '0 : r_rd_col + COL_W'(1);
                end
                if (w_hs) begin
                    r_acc_cnt <= r_acc_cnt + CNT_W'(1);
                end
                r_det_count <= w_det_next;
                if (w_det_edge) begin
                    r_idle <= '0;
                end else if (r_state == ST_DRAIN) begin
                    r_idle <= r_idle + IDLE_W'(1);
                end
                if (w_timeout_set) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    stream_skid_fifo #(
        .W(BEAT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wdata ({mem_rd_data, r_if_tlast, r_if_tuser}),
        .i_push  (r_inflight),
        .i_ready (m_axis_tready),
        .o_rdata (w_fifo_rdata),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    // Payload is forced to zero while no beat is offered so idle outputs read as 0.
    assign m_axis_tvalid = w_fifo_valid;
    assign {m_axis_tdata, m_axis_tlast, m_axis_tuser} = w_fifo_valid ? w_fifo_rdata : '0;
    assign mem_rd_en     = w_rd_en;
    assign mem_addr      = r_rd_cnt[A_W-1:0];
    assign det_count     = r_det_count;
    assign det_timeout   = r_timeout;

endmodule

// File: tb/tb_yolo_frame_streamer.sv
// tb/tb_yolo_frame_streamer.sv - randomized self-checking bench for yolo_frame_streamer
module tb_yolo_frame_streamer;

    localparam int IMGW = 4;
    localparam int IMGH = 2;
    localparam int FPIX = IMGW * IMGH;
    localparam int MAXF = 2;
    localparam int DETS = 3;
    localparam int TOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  num_frames = 2'd0;
    logic        mem_rd_en;
    logic [3:0]  mem_addr;
    logic [23:0] mem_rd_data = 24'd0;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        det_valid = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] det_count;
    logic        det_timeout;

    logic [23:0] mem [16];
    logic [25:0] got [$];
    logic [3:0]  addrs [$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          done_cnt;
    int          done_cyc;
    int          last_edge;
    logic        stalled = 1'b0;
    logic [25:0] held = '0;
    logic        det_prev_tb = 1'b0;

    yolo_frame_streamer #(
        .PIX_W(24), .IMG_W(IMGW), .IMG_H(IMGH), .MAX_FRAMES(MAXF),
        .DETS_PER_FRAME(DETS), .DET_W(16), .TIMEOUT(TOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_frames(num_frames),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .det_valid(det_valid), .busy(busy),
        .done(done), .det_count(det_count), .det_timeout(det_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic observe();
        cyc++;
        if (!rst) begin
            if (mem_rd_en) addrs.push_back(mem_addr);
            if (stalled)
                chk("stall_hold", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser}),
                    64'({1'b1, held}));
            if (m_axis_tvalid && m_axis_tready)
                got.push_back({m_axis_tdata, m_axis_tlast, m_axis_tuser});
            stalled = m_axis_tvalid && !m_axis_tready;
            held    = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (det_valid && !det_prev_tb) last_edge = cyc;
        end else begin
            stalled = 1'b0;
        end
        det_prev_tb = det_valid;
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int nf_req, input bit rnd_ready, input int ndets);
        int nf, n, guard;
        bit to;
        logic [25:0] e;
        nf = (nf_req > MAXF) ? MAXF : nf_req;
        n  = nf * FPIX;
        for (int i = 0; i < 16; i++) mem[i] = 24'($urandom);
        got.delete();
        addrs.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        last_edge = -1;
        num_frames    = 2'(nf_req);
        m_axis_tready = rnd_ready ? 1'($urandom) : 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rd_en_cycle1", 64'(mem_rd_en), 64'(nf > 0));
        chk("done_cycle1", 64'(done), 64'(nf == 0));
        step();
        chk("tvalid_cycle2", 64'(m_axis_tvalid), 64'(nf > 0));
        guard = 0;
        while (got.size() < n && guard < 400) begin
            m_axis_tready = rnd_ready ? 1'($urandom) : 1'b1;
            start = (guard == 3);
            step();
            guard++;
        end
        start = 1'b0;
        m_axis_tready = 1'b1;
        chk("beat_budget", 64'(guard < 400), 64'd1);
        if (nf > 0) begin
            chk("busy_in_drain", 64'(busy), 64'd1);
            chk("no_early_done", 64'(done_cnt), 64'd0);
        end
        for (int k = 0; k < ndets; k++) begin
            det_valid = 1'b1;
            step();
            if ($urandom_range(1, 0) == 1) step();
            det_valid = 1'b0;
            step();
            step();
        end
        guard = 0;
        while (done_cnt == 0 && guard < 60) begin
            step();
            guard++;
        end
        chk("done_seen", 64'(done_cnt), 64'd1);
        to = (nf > 0) && (ndets < nf * DETS);
        if (nf > 0)
            chk("done_cycle", 64'(done_cyc), 64'(to ? last_edge + TOUT + 1 : last_edge + 1));
        chk("det_count", 64'(det_count), 64'(ndets));
        chk("det_timeout", 64'(det_timeout), 64'(to));
        chk("busy_after", 64'(busy), 64'd0);
        chk("beat_total", 64'(got.size()), 64'(n));
        chk("read_total", 64'(addrs.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            e = {mem[i], 1'(i % IMGW == IMGW - 1), 1'(i % FPIX == 0)};
            if (i < got.size()) chk("beat", 64'(got[i]), 64'(e));
            if (i < addrs.size()) chk("addr", 64'(addrs[i]), 64'(i));
        end
        det_valid = 1'b1;
        step();
        det_valid = 1'b0;
        step();
        step();
        chk("idle_edge_ignored", 64'(det_count), 64'(ndets));
        chk("timeout_held", 64'(det_timeout), 64'(to));
        chk("single_done", 64'(done_cnt), 64'd1);
    endtask

    initial begin
        step();
        step();
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_payload", 64'({m_axis_tdata, m_axis_tlast, m_axis_tuser}), 64'd0);
        chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_status", 64'({busy, done, det_timeout}), 64'd0);
        chk("rst_det_count", 64'(det_count), 64'd0);
        rst = 1'b0;
        step();

        run(1, 1'b0, 3);
        run(1, 1'b1, 3);
        run(2, 1'b0, 6);
        run(3, 1'b1, 6);
        run(1, 1'b0, 2);

        for (int i = 0; i < 16; i++) mem[i] = 24'($urandom);
        num_frames    = 2'd1;
        m_axis_tready = 1'b1;
        got.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int g = 0; g < 50 && got.size() < 5; g++) step();
        chk("beats_before_rst", 64'(got.size()), 64'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_rd_en", 64'(mem_rd_en), 64'd0);
        chk("midrst_det_count", 64'(det_count), 64'd0);
        step();
        run(1, 1'b0, 3);

        run(0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
